sc_stoch_to_bin_bi: RTL and testbench
=====================================

# sc_stoch_to_bin_bi

Bipolar stochastic-to-binary converter. It counts the 1s in a bipolar stochastic bitstream over a fixed window of 2^N valid bits and reports the encoded value as a signed integer. The block sits at the output end of the SC datapath, after `sc_multiplier_bi` and the other stream operators, and turns their result streams back into binary for the host or the checker.

## Interface
Parameters:
- `N`, default 8: log2 of the window length. Window length L = 2^N valid bits.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begins a conversion window when sampled high in IDLE or DONE.
- `in_valid`, input, 1: `in_bit` is a valid stream sample this cycle.
- `in_bit`, input, 1: stochastic stream bit.
- `busy`, output, 1: high while in COUNT.
- `done`, output, 1: one-cycle pulse; `ones` and `value` updated this cycle.
- `ones`, output, N+1: count of 1s in the last completed window (0..L).
- `value`, output, N+2, signed two's complement: 2*ones − L (−L..+L). This represents the bipolar value scaled by L.

## Operation
- States: IDLE, COUNT, DONE. Reset state is IDLE.
- **IDLE**
  - `start`=1 → COUNT, with the sample counter and ones counter cleared to 0.
  - `in_valid` is ignored.
- **COUNT**
  - Each cycle with `in_valid`=1: the sample counter increments, and the ones counter increments if `in_bit`=1.
  - `in_valid`=0 cycles are skipped; the window stays open, with no timeout.
  - When the L-th valid sample is taken → DONE.
  - `start` is ignored in COUNT.
- **DONE** lasts exactly one cycle.
  - `done`=1. `ones` and `value` present the new result.
  - Next state:
    - `start`=1 → COUNT with counters cleared (back-to-back windows).
    - Otherwise → IDLE.
  - `in_valid` in the DONE cycle is not counted.
- Arithmetic:
  - The ones counter is N+1 bits and cannot overflow, since at most L increments occur per window.
  - The sample counter is N+1 bits, with terminal value L.
  - `value` = {ones, 1'b0} − L, computed in N+2 bits. No saturation is needed.
- Output registers:
  - `ones` and `value` are loaded only on the COUNT→DONE transition.
  - They hold until the next completed window, or until reset.
- Reset mid-window: the partial count is discarded. The state returns to IDLE, and `done` does not pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `ones`=0, `value`=0, state IDLE.
- The `in_bit` present in the same cycle that `start` is sampled is not counted. Counting begins with the next cycle.
- With `start` high in cycle 0 and `in_valid`=1 every cycle:
  - `busy` is high in cycles 1..L.
  - `done` and the new outputs appear in cycle L+1.
  - Latency is L+1 cycles.
- Back-to-back operation (`start`=1 in the DONE cycle) gives one idle sample slot between windows.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- Macro: `SC_S2B_CONTINUOUS_EN`.
- **Defined:**
  - DONE always proceeds to COUNT with counters cleared, regardless of `start`.
  - After the first `start`, the block converts consecutive windows indefinitely, and `done` pulses once per window.
  - Only reset returns the block to IDLE.
- **Undefined:** behaviour is as in Operation. Each window requires `start`.

## Test plan
All scenarios use N=4, L=16.
- **Reset:** `rst_n`=0 for 3 cycles, then release → `busy`=0, `done`=0, `ones`=0, `value`=0, no `done` pulse.
- **All ones:** `start`, then 16 cycles of `in_valid`=1, `in_bit`=1 → `done` in cycle 17, `ones`=16, `value`=+16. Repeat with all zeros → `ones`=0, `value`=−16.
- **Alternating stream and SC chain:**
  - `in_bit`=1,0,1,0… for 16 bits → `ones`=8, `value`=0.
  - Feed `in_bit` from `sc_multiplier_bi` with x=y=1010… → `ones`=16, `value`=+16.
- **Valid gaps:** `in_valid` high every other cycle, `in_bit`=1 → `done` 32 cycles after `start`, `ones`=16. A `start` pulse mid-window is ignored, with no restart and the count unchanged.
- **Reset mid-window:**
  - After 5 counted 1s, pulse `rst_n` low → `busy`=0, outputs 0, no `done`.
  - A new `start` plus 16 zeros → `value`=−16.
- **Back-to-back:** `start` held high across the DONE cycle → second window begins, `done` pulses exactly 17 cycles after the first. With `SC_S2B_CONTINUOUS_EN` defined and a single `start` → `done` every 17 cycles for at least 3 windows.

Source files
------------

// File: rtl/sc_stoch_to_bin_bi.sv
`default_nettype none
// ============================================================================
// Module      : sc_stoch_to_bin_bi
// Description : Bipolar stochastic-to-binary converter. Counts 1s over a
//               window of 2^N valid bits and reports ones and 2*ones - 2^N.
//               Macro SC_S2B_CONTINUOUS_EN: convert windows back-to-back
//               forever after the first start.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_stoch_to_bin_bi #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic                in_bit,
    output logic                busy,
    output logic                done,
    output logic [N:0]          ones,
    output logic signed [N+1:0] value
);

    localparam logic [1:0]   c_st_idle    = 2'd0;
    localparam logic [1:0]   c_st_count   = 2'd1;
    localparam logic [1:0]   c_st_done    = 2'd2;
    localparam logic [N:0]   c_win_len    = {1'b1, {N{1'b0}}};
    localparam logic [N+1:0] c_win_len_ext = {2'b01, {N{1'b0}}};

    logic [1:0]   r_state;
    logic [N:0]   r_cnt;
    logic [N:0]   r_ones_acc;
    logic         r_busy;
    logic         r_done;
    logic [N:0]   r_ones;
    logic [N+1:0] r_value;

    logic         w_restart;
    logic [N:0]   w_cnt_next;
    logic [N:0]   w_ones_next;
    logic [N+1:0] w_value_next;

    assign w_cnt_next   = r_cnt + {{N{1'b0}}, 1'b1};
    assign w_ones_next  = r_ones_acc + {{N{1'b0}}, in_bit};
    // Modular subtraction in N+2 bits yields the two's-complement result.
    assign w_value_next = {w_ones_next, 1'b0} - c_win_len_ext;

`ifdef SC_S2B_CONTINUOUS_EN
    assign w_restart = 1'b1;
`else
    assign w_restart = start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_ones_acc <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ones     <= '0;
            r_value    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state    <= c_st_count;
                        r_cnt      <= '0;
                        r_ones_acc <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                c_st_count: begin
                    if (in_valid) begin
                        r_cnt      <= w_cnt_next;
                        r_ones_acc <= w_ones_next;
                        if (w_cnt_next == c_win_len) begin
                            r_state <= c_st_done;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ones  <= w_ones_next;
                            r_value <= w_value_next;
                        end
                    end
                end
                c_st_done: begin
                    if (w_restart) begin
                        r_state    <= c_st_count;
                        r_cnt      <= '0;
                        r_ones_acc <= '0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign ones  = r_ones;
    assign value = $signed(r_value);

endmodule
`default_nettype wire

// File: tb/tb_sc_stoch_to_bin_bi.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_stoch_to_bin_bi
// Description : Self-checking bench for sc_stoch_to_bin_bi with N=4 (L=16);
//               window results compared against a counting model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_stoch_to_bin_bi;

    localparam int N = 4;
    localparam int L = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_bit = 1'b0;
    logic                busy;
    logic                done;
    logic [N:0]          ones;
    logic signed [N+1:0] value;

    int n_checks = 0;
    int n_pass   = 0;

    bit q_valid[$];
    bit q_bit[$];

    int                  obs_done_cyc;
    int                  obs_done_cnt;
    int                  obs_busy_cnt;
    logic [N:0]          obs_ones;
    logic signed [N+1:0] obs_value;

    sc_stoch_to_bin_bi #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .busy     (busy),
        .done     (done),
        .ones     (ones),
        .value    (value)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Cycle 0 carries start (with a valid 1 that must not count); cycle c>=1 drives queue entry c-1.
    task automatic run_window(input int mid_start, input int budget);
        obs_done_cyc = -1; obs_done_cnt = 0; obs_busy_cnt = 0;
        obs_ones = 'x; obs_value = 'x;
        start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= budget; c++) begin
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = c; obs_ones = ones; obs_value = value;
                end
            end
            if (busy === 1'b1) obs_busy_cnt++;
            start    = (c == mid_start);
            in_valid = (c - 1 < q_valid.size()) ? q_valid[c-1] : 1'b0;
            in_bit   = (c - 1 < q_bit.size())   ? q_bit[c-1]   : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    endtask

    // Reference: the window closes on the L-th valid entry; done follows one cycle later.
    task automatic model(output int exp_cyc, output int exp_ones);
        int seen;
        seen = 0; exp_ones = 0; exp_cyc = -1;
        foreach (q_valid[i]) begin
            if (q_valid[i] && exp_cyc < 0) begin
                seen++;
                if (q_bit[i]) exp_ones++;
                if (seen == L) exp_cyc = i + 2;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, ones, value} !== '0) $display("FAIL reset_hold: got busy=%b done=%b ones=%0d value=%0d, need all 0", busy, done, ones, value);
        else n_pass++;
        rst_n = 1'b1;
        obs_done_cnt = 0; obs_busy_cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done !== 1'b0) obs_done_cnt++;
            if (busy !== 1'b0) obs_busy_cnt++;
        end
        n_checks++;
        if (obs_done_cnt != 0 || obs_busy_cnt != 0 || ones !== '0 || value !== '0)
            $display("FAIL reset_release: got done_cnt=%0d busy_cnt=%0d ones=%0d value=%0d, need 0s", obs_done_cnt, obs_busy_cnt, ones, value);
        else n_pass++;
    endtask

    task automatic test_const(input bit b);
        int ec, eo;
        do_reset();
        q_valid.delete(); q_bit.delete();
        for (int i = 0; i < L; i++) begin q_valid.push_back(1'b1); q_bit.push_back(b); end
        model(ec, eo);
        run_window(-1, ec + 4);
        n_checks++;
        if (obs_done_cyc != ec) $display("FAIL const%0d_latency: got done cycle %0d, need %0d", b, obs_done_cyc, ec);
        else n_pass++;
        n_checks++;
        if (obs_ones !== 5'(eo) || obs_value !== 6'(2 * eo - L))
            $display("FAIL const%0d_result: got ones=%0d value=%0d, need ones=%0d value=%0d", b, obs_ones, obs_value, eo, 2 * eo - L);
        else n_pass++;
        n_checks++;
        if (obs_busy_cnt != L || obs_done_cnt != 1)
            $display("FAIL const%0d_busy: got busy cycles=%0d dones=%0d, need %0d and 1", b, obs_busy_cnt, obs_done_cnt, L);
        else n_pass++;
    endtask

    task automatic test_alternating();
        int ec, eo;
        do_reset();
        q_valid.delete(); q_bit.delete();
        for (int i = 0; i < L; i++) begin q_valid.push_back(1'b1); q_bit.push_back(i % 2 == 0); end
        model(ec, eo);
        run_window(-1, ec + 4);
        n_checks++;
        if (obs_done_cyc != ec || obs_ones !== 5'(eo) || obs_value !== 6'(2 * eo - L))
            $display("FAIL alternating: got cyc=%0d ones=%0d value=%0d, need cyc=%0d ones=%0d value=%0d", obs_done_cyc, obs_ones, obs_value, ec, eo, 2 * eo - L);
        else n_pass++;
    endtask

    // Stream as produced by a bipolar (XNOR) multiplier of x=y=1010...
    task automatic test_sc_chain();
        int ec, eo;
        bit x, y;
        do_reset();
        q_valid.delete(); q_bit.delete();
        for (int i = 0; i < L; i++) begin
            x = (i % 2 == 0); y = (i % 2 == 0);
            q_valid.push_back(1'b1); q_bit.push_back(~(x ^ y));
        end
        model(ec, eo);
        run_window(-1, ec + 4);
        n_checks++;
        if (obs_ones !== 5'(eo) || obs_value !== 6'(2 * eo - L))
            $display("FAIL sc_chain: got ones=%0d value=%0d, need ones=%0d value=%0d", obs_ones, obs_value, eo, 2 * eo - L);
        else n_pass++;
    endtask

    task automatic test_valid_gaps();
        int ec, eo;
        do_reset();
        q_valid.delete(); q_bit.delete();
        for (int i = 0; i < 2 * L; i++) begin q_valid.push_back(i % 2 == 0); q_bit.push_back(1'b1); end
        model(ec, eo);
        run_window(11, ec + 4);
        n_checks++;
        if (obs_done_cyc != ec || obs_done_cyc != 2 * L)
            $display("FAIL gaps_latency: got done cycle %0d, need %0d", obs_done_cyc, ec);
        else n_pass++;
        n_checks++;
        if (obs_ones !== 5'(eo) || obs_done_cnt != 1)
            $display("FAIL gaps_result: got ones=%0d dones=%0d, need ones=%0d dones=1", obs_ones, obs_done_cnt, eo);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ec, eo;
        do_reset();
        q_valid.delete(); q_bit.delete();
        for (int i = 0; i < L; i++) begin q_valid.push_back(1'b1); q_bit.push_back(1'b1); end
        run_window(-1, L + 4);
        n_checks++;
        if (obs_ones !== 5'(L)) $display("FAIL midrst_pre: got ones=%0d, need %0d", obs_ones, L);
        else n_pass++;
        start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, ones, value} !== '0) $display("FAIL midrst_async: got busy=%b done=%b ones=%0d value=%0d, need all 0", busy, done, ones, value);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        obs_done_cnt = 0; obs_busy_cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done !== 1'b0) obs_done_cnt++;
            if (busy !== 1'b0) obs_busy_cnt++;
        end
        in_valid = 1'b0; in_bit = 1'b0;
        n_checks++;
        if (obs_done_cnt != 0 || obs_busy_cnt != 0) $display("FAIL midrst_quiet: got dones=%0d busy cycles=%0d, need 0", obs_done_cnt, obs_busy_cnt);
        else n_pass++;
        q_valid.delete(); q_bit.delete();
        for (int i = 0; i < L; i++) begin q_valid.push_back(1'b1); q_bit.push_back(1'b0); end
        model(ec, eo);
        run_window(-1, ec + 4);
        n_checks++;
        if (obs_done_cyc != ec || obs_value !== 6'(2 * eo - L))
            $display("FAIL midrst_after: got cyc=%0d value=%0d, need cyc=%0d value=%0d", obs_done_cyc, obs_value, ec, 2 * eo - L);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dcyc[$];
        int exp_n;
        do_reset();
        start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 60; c++) begin
            if (done === 1'b1) dcyc.push_back(c);
`ifdef SC_S2B_CONTINUOUS_EN
            start = 1'b0;
`else
            start = (c <= L + 1);
`endif
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0;
`ifdef SC_S2B_CONTINUOUS_EN
        exp_n = 3;
`else
        exp_n = 2;
`endif
        n_checks++;
        if (dcyc.size() != exp_n) $display("FAIL b2b_count: got %0d done pulses, need %0d", dcyc.size(), exp_n);
        else n_pass++;
        n_checks++;
        if (dcyc.size() < 2 || dcyc[0] != L + 1 || dcyc[1] != 2 * (L + 1))
            $display("FAIL b2b_spacing: got first=%0d second=%0d, need %0d and %0d",
                     dcyc.size() > 0 ? dcyc[0] : -1, dcyc.size() > 1 ? dcyc[1] : -1, L + 1, 2 * (L + 1));
        else n_pass++;
        n_checks++;
        if (ones !== 5'(L) || value !== 6'(L)) $display("FAIL b2b_result: got ones=%0d value=%0d, need %0d and %0d", ones, value, L, L);
        else n_pass++;
    endtask

    task automatic test_random();
        int ec, eo, nv;
        for (int w = 0; w < 6; w++) begin
            do_reset();
            q_valid.delete(); q_bit.delete();
            nv = 0;
            while (nv < L) begin
                q_valid.push_back($urandom_range(0, 3) != 0);
                q_bit.push_back(1'($urandom));
                if (q_valid[q_valid.size()-1]) nv++;
            end
            repeat (3) begin q_valid.push_back(1'($urandom)); q_bit.push_back(1'($urandom)); end
            model(ec, eo);
            run_window(-1, ec + 3);
            n_checks++;
            if (obs_done_cyc != ec || obs_ones !== 5'(eo) || obs_value !== 6'(2 * eo - L))
                $display("FAIL random_w%0d: got cyc=%0d ones=%0d value=%0d, need cyc=%0d ones=%0d value=%0d",
                         w, obs_done_cyc, obs_ones, obs_value, ec, eo, 2 * eo - L);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_const(1'b1);
        test_const(1'b0);
        test_alternating();
        test_sc_chain();
        test_valid_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
